// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
// Build option: MEM_WR_VERIFY_EN adds the post-write verify-read states.
package mem_pkg;

  localparam int RD_WAIT_DEF  = 2;
  localparam int WR_PULSE_DEF = 2;
  localparam int ADDR_W_DEF   = 20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ACT,
    ST_RD_DONE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_WAIT_REL
`ifdef MEM_WR_VERIFY_EN
    ,
    ST_VFY_RD,
    ST_VFY_CMP
`endif
  } mem_state_t;

  typedef struct packed {
    logic ce_n;
    logic ub_n;
    logic lb_n;
    logic oe_n;
    logic we_n;
  } sram_strb_t;

  localparam sram_strb_t SRAM_STRB_IDLE = '1;

  // Strobe pattern the SRAM pins should show while the FSM sits in a state.
  function automatic sram_strb_t strobes_for(mem_state_t st);
    sram_strb_t s;
    s = SRAM_STRB_IDLE;
    case (st)
      ST_RD_ACT, ST_RD_DONE: begin
        s.ce_n = 1'b0; s.ub_n = 1'b0; s.lb_n = 1'b0; s.oe_n = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        s.ce_n = 1'b0; s.ub_n = 1'b0; s.lb_n = 1'b0;
      end
      ST_WR_PULSE: begin
        s.ce_n = 1'b0; s.ub_n = 1'b0; s.lb_n = 1'b0; s.we_n = 1'b0;
      end
`ifdef MEM_WR_VERIFY_EN
      ST_VFY_RD: begin
        s.ce_n = 1'b0; s.ub_n = 1'b0; s.lb_n = 1'b0; s.oe_n = 1'b0;
      end
      ST_VFY_CMP: begin
        s.ce_n = 1'b0; s.ub_n = 1'b0; s.lb_n = 1'b0;
      end
`endif
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with zero flag, timing read waits, write pulses
// and verify reads inside mem_access_ctrl.
module mem_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: give every comb-assigned signal a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR owner that turns ISDU Mem_OE/Mem_WE requests into registered SRAM
// strobe sequences. Build option: MEM_WR_VERIFY_EN (read-back after each write).
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int RD_WAIT  = RD_WAIT_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       Bus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  output logic [15:0]       MAR,
  output logic [15:0]       MDR,
  output logic              Mem_Ready,
  output logic              Mem_Err,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_DQ_O,
  input  logic [15:0]       SRAM_DQ_I,
  output logic              SRAM_DQ_OE,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

  mem_state_t        state_q, state_d;
  logic [15:0]       mar_q, mar_d;
  logic [15:0]       mdr_q, mdr_d;
  logic [15:0]       rdbuf_q, rdbuf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  sram_strb_t        strb_q, strb_d;

  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              wr_busy;

  mem_wait_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign wr_busy = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                   (state_q == ST_WR_HOLD);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    rdbuf_d = rdbuf_q;
    err_d   = err_q;
    cnt_dec = 1'b0;

    mar_d = LD_MAR ? Bus : mar_q;
    mdr_d = mdr_q;
    // Write data is frozen while the pad is being driven.
    if (LD_MDR && !wr_busy) begin
      mdr_d = Mem_OE ? Bus : rdbuf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!Mem_WE) begin
          state_d = ST_WR_SETUP;
          addr_d  = ADDR_W'(mar_q);
          dq_o_d  = mdr_q;
        end else if (!Mem_OE) begin
          state_d = ST_RD_ACT;
          addr_d  = ADDR_W'(mar_q);
        end
      end
      ST_RD_ACT: begin
        if (cnt_zero) begin
          rdbuf_d = SRAM_DQ_I;
          state_d = ST_RD_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RD_DONE:  state_d = ST_WAIT_REL;
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: begin
        if (cnt_zero) state_d = ST_WR_HOLD;
        else          cnt_dec = 1'b1;
      end
`ifdef MEM_WR_VERIFY_EN
      ST_WR_HOLD:  state_d = ST_VFY_RD;
      ST_VFY_RD: begin
        if (cnt_zero) begin
          if (SRAM_DQ_I != dq_o_q) err_d = 1'b1;
          state_d = ST_VFY_CMP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_VFY_CMP:  state_d = ST_WAIT_REL;
`else
      ST_WR_HOLD:  state_d = ST_WAIT_REL;
`endif
      ST_WAIT_REL: begin
        if (Mem_OE && Mem_WE) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase

    // Any state change reloads the counter; untimed states simply get zero.
    cnt_load = (state_d != state_q);
    case (state_d)
      ST_RD_ACT:   cnt_load_val = RD_LOAD;
      ST_WR_PULSE: cnt_load_val = WR_LOAD;
`ifdef MEM_WR_VERIFY_EN
      ST_VFY_RD:   cnt_load_val = RD_LOAD;
`endif
      default:     cnt_load_val = '0;
    endcase

    // Pin outputs are decoded from the next state so they change with it.
    strb_d  = strobes_for(state_d);
    dq_oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
              (state_d == ST_WR_HOLD);
`ifdef MEM_WR_VERIFY_EN
    ready_d = (state_d == ST_RD_DONE) || (state_d == ST_VFY_CMP);
`else
    ready_d = (state_d == ST_RD_DONE) || (state_d == ST_WR_HOLD);
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdbuf_q <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      strb_q  <= SRAM_STRB_IDLE;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdbuf_q <= rdbuf_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
    end
  end

  assign MAR        = mar_q;
  assign MDR        = mdr_q;
  assign Mem_Ready  = ready_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_DQ_O  = dq_o_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign SRAM_CE_N  = strb_q.ce_n;
  assign SRAM_UB_N  = strb_q.ub_n;
  assign SRAM_LB_N  = strb_q.lb_n;
  assign SRAM_OE_N  = strb_q.oe_n;
  assign SRAM_WE_N  = strb_q.we_n;
`ifdef MEM_WR_VERIFY_EN
  assign Mem_Err    = err_q;
`else
  assign Mem_Err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural async SRAM model.
// Also exercises the verify path when built with MEM_WR_VERIFY_EN.
module tb_mem_access_ctrl;

`ifdef MEM_WR_VERIFY_EN
  localparam logic HOLD_RDY = 1'b0;
  localparam int   BOTH_OE  = 2;
`else
  localparam logic HOLD_RDY = 1'b1;
  localparam int   BOTH_OE  = 0;
`endif

  logic        Clk, Reset;
  logic [15:0] Bus;
  logic        LD_MAR, LD_MDR, Mem_OE, Mem_WE;
  logic [15:0] MAR, MDR;
  logic        Mem_Ready, Mem_Err;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_O, SRAM_DQ_I;
  logic        SRAM_DQ_OE, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;

  int total, bad;
  int oe_lo_cnt, we_lo_cnt, rdy_cnt, overlap_cnt;
  logic stuck_en;

  mem_access_ctrl #(.RD_WAIT(2), .WR_PULSE(2), .ADDR_W(20)) dut (
    .Clk(Clk), .Reset(Reset), .Bus(Bus), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .MAR(MAR), .MDR(MDR),
    .Mem_Ready(Mem_Ready), .Mem_Err(Mem_Err), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_I(SRAM_DQ_I), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: unwritten words return a fixed per-address pattern.
  logic [15:0] mem     [0:65535];
  bit          written [0:65535];

  function automatic logic [15:0] sram_rd(input logic [15:0] a);
    if (written[a]) return mem[a];
    case (a)
      16'h3000: return 16'h1234;
      16'h0050: return 16'hCAFE;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) begin
      mem[SRAM_ADDR[15:0]]     <= SRAM_DQ_O;
      written[SRAM_ADDR[15:0]] <= 1'b1;
    end
  end

  always_comb begin
    SRAM_DQ_I = 16'h0000;
    if (!SRAM_CE_N && !SRAM_OE_N)
      SRAM_DQ_I = sram_rd(SRAM_ADDR[15:0]) & (stuck_en ? 16'hFFFE : 16'hFFFF);
  end

  always @(negedge Clk) begin
    if (!SRAM_OE_N) oe_lo_cnt++;
    if (!SRAM_WE_N) we_lo_cnt++;
    if (Mem_Ready)  rdy_cnt++;
    if (!SRAM_OE_N && !SRAM_WE_N) overlap_cnt++;
  end

  function automatic logic [4:0] strb();
    return {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (Mem_Ready) break;
    end
  endtask

  task automatic load_reg(input logic [15:0] val, input logic is_mar);
    Bus = val;
    LD_MAR = is_mar;
    LD_MDR = !is_mar;
    tick();
    LD_MAR = 1'b0;
    LD_MDR = 1'b0;
  endtask

  int n, o0, w0, r0;

  initial begin
    total = 0; bad = 0;
    Reset = 1'b1; Bus = '0; LD_MAR = 1'b0; LD_MDR = 1'b0;
    Mem_OE = 1'b0; Mem_WE = 1'b1; stuck_en = 1'b0;

    // Reset held with a read request pending
    repeat (3) tick();
    check("rst_strb", strb(), 5'h1F);
    check("rst_mar", MAR, 0);
    check("rst_mdr", MDR, 0);
    check("rst_rdy", Mem_Ready, 0);
    check("rst_dqoe", SRAM_DQ_OE, 0);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_dqo", SRAM_DQ_O, 0);
    check("rst_err", Mem_Err, 0);
    Reset = 1'b0;
    tick();
    check("rel_oe_n", SRAM_OE_N, 0);
    check("rel_ce_n", SRAM_CE_N, 0);
    Mem_OE = 1'b1;
    wait_ready(6, n);
    check("rel_rd_lat", n, 2);
    tick(); tick();

    // Read 0x3000 with LD_MDR held; MDR must take SRAM data, not Bus
    load_reg(16'h3000, 1'b1);
    check("mar_ld", MAR, 16'h3000);
    Bus = 16'hFFFF; Mem_OE = 1'b0; LD_MDR = 1'b1;
    tick();
    check("rd1_oe_n", SRAM_OE_N, 0);
    check("rd1_addr", SRAM_ADDR, 20'h03000);
    check("rd1_rdy", Mem_Ready, 0);
    tick();
    check("rd2_oe_n", SRAM_OE_N, 0);
    check("rd2_rdy", Mem_Ready, 0);
    tick();
    check("rd3_rdy", Mem_Ready, 1);
    check("rd3_oe_n", SRAM_OE_N, 0);
    tick();
    check("rd4_rdy", Mem_Ready, 0);
    check("rd4_oe_n", SRAM_OE_N, 1);
    check("rd4_mdr", MDR, 16'h1234);
    r0 = rdy_cnt;
    repeat (3) tick();
    check("rd_held_single", rdy_cnt - r0, 0);
    check("rd_held_strb", strb(), 5'h1F);
    Mem_OE = 1'b1; LD_MDR = 1'b0;
    tick();

    // Request released mid-read; WAIT_REL must exit at once
    load_reg(16'h0050, 1'b1);
    Mem_OE = 1'b0;
    tick();
    Mem_OE = 1'b1;
    wait_ready(6, n);
    check("rd_rel_lat", n, 2);
    tick(); tick();
    Mem_OE = 1'b0; LD_MDR = 1'b1;
    tick();
    check("exit_oe_n", SRAM_OE_N, 0);
    wait_ready(6, n);
    check("rd_cafe_lat", n, 2);
    tick();
    check("rd_cafe_mdr", MDR, 16'hCAFE);
    Mem_OE = 1'b1; LD_MDR = 1'b0;
    tick(); tick();

    // Write 0xBEEF to 0x0010 with Mem_WE held low
    load_reg(16'h0010, 1'b1);
    load_reg(16'hBEEF, 1'b0);
    check("mdr_bus", MDR, 16'hBEEF);
    Bus = 16'h5555;
    w0 = we_lo_cnt; r0 = rdy_cnt;
    Mem_WE = 1'b0;
    tick();
    check("wr1_strb", strb(), 5'b00011);
    check("wr1_dqoe", SRAM_DQ_OE, 1);
    check("wr1_dqo", SRAM_DQ_O, 16'hBEEF);
    check("wr1_addr", SRAM_ADDR, 20'h00010);
    LD_MDR = 1'b1;
    tick();
    check("wr2_we_n", SRAM_WE_N, 0);
    check("wr2_dqoe", SRAM_DQ_OE, 1);
    tick();
    check("wr3_we_n", SRAM_WE_N, 0);
    tick();
    check("wr4_we_n", SRAM_WE_N, 1);
    check("wr4_dqoe", SRAM_DQ_OE, 1);
    check("wr4_rdy", Mem_Ready, HOLD_RDY);
    check("wr4_mdr", MDR, 16'hBEEF);
    LD_MDR = 1'b0;
`ifdef MEM_WR_VERIFY_EN
    wait_ready(8, n);
    check("vfy_lat", n, 3);
    check("vfy_ok_err", Mem_Err, 0);
`endif
    tick();
    check("wr5_dqoe", SRAM_DQ_OE, 0);
    check("wr5_rdy", Mem_Ready, 0);
    check("wr5_strb", strb(), 5'h1F);
    repeat (5) tick();
    Mem_WE = 1'b1;
    tick();
    check("wr_pulse_cycles", we_lo_cnt - w0, 2);
    check("wr_ready_cnt", rdy_cnt - r0, 1);
    check("sram_0010", sram_rd(16'h0010), 16'hBEEF);

    // Read and write requested together: write wins
    load_reg(16'h0020, 1'b1);
    load_reg(16'hA5A5, 1'b0);
    o0 = oe_lo_cnt; w0 = we_lo_cnt; r0 = rdy_cnt;
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    repeat (12) tick();
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    tick(); tick();
    check("both_oe_lo", oe_lo_cnt - o0, BOTH_OE);
    check("both_we_lo", we_lo_cnt - w0, 2);
    check("both_rdy", rdy_cnt - r0, 1);
    check("sram_0020", sram_rd(16'h0020), 16'hA5A5);

    // Reset during the write pulse
    load_reg(16'h0030, 1'b1);
    r0 = rdy_cnt;
    Mem_WE = 1'b0;
    tick(); tick();
    check("rstw_pulse_we_n", SRAM_WE_N, 0);
    Reset = 1'b1;
    tick();
    check("rstw_we_n", SRAM_WE_N, 1);
    check("rstw_dqoe", SRAM_DQ_OE, 0);
    check("rstw_strb", strb(), 5'h1F);
    check("rstw_rdy", Mem_Ready, 0);
    check("rstw_mar", MAR, 0);
    Reset = 1'b0; Mem_WE = 1'b1;
    repeat (3) tick();
    check("rstw_no_rdy", rdy_cnt - r0, 0);
    check("rstw_idle_strb", strb(), 5'h1F);
    check("no_oe_we_overlap", overlap_cnt, 0);

`ifdef MEM_WR_VERIFY_EN
    // Bit 0 stuck at 0 in the SRAM: verify must flag and hold the error
    load_reg(16'h0040, 1'b1);
    load_reg(16'h0001, 1'b0);
    stuck_en = 1'b1;
    Mem_WE = 1'b0;
    wait_ready(12, n);
    check("stuck_lat", n, 7);
    check("stuck_err", Mem_Err, 1);
    Mem_WE = 1'b1;
    repeat (3) tick();
    check("stuck_err_sticky", Mem_Err, 1);
    stuck_en = 1'b0;
    load_reg(16'h0002, 1'b0);
    Mem_WE = 1'b0;
    wait_ready(12, n);
    check("clean_lat", n, 7);
    check("clean_err_sticky", Mem_Err, 1);
    Mem_WE = 1'b1;
    tick(); tick();
    Reset = 1'b1;
    tick();
    check("err_rst", Mem_Err, 0);
    Reset = 1'b0;
    tick();
`else
    check("err_tied", Mem_Err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
